sap1_controller_sequencer: RTL and testbench

- Controller-sequencer for the SAP-1 datapath. It issues the load-enable (n_L*) and output-enable (E*) lines that the ci74173-style bus registers, PC, MAR, RAM, ALU and output port obey.
- A 6-state ring counter (T1..T6) steps through fetch and execute. A microcode decoder turns the ring state plus the instruction-register opcode into the control word.
- The ring advances on the falling clk edge, so the control word is stable at each rising edge, where the registers load.

---
 rtl/sap1_controller_sequencer.sv | 167 ++++++++++++++++
 tb/tb_sap1_controller_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer.
// A six-state ring (T1..T6) advances on the falling clock edge so that the
// control word is settled at every rising edge, where the datapath registers
// load. The control word is decoded from the ring state, the IR opcode and
// the halt flag.
//
// state | meaning
// ------+----------------------------------------------------------
// T1    | address state: PC onto bus, MAR loads
// T2    | increment state: PC counts up
// T3    | memory state: RAM onto bus, IR loads
// T4    | execute 1: operand address to MAR / A to output / halt point
// T5    | execute 2: RAM operand to A or B
// T6    | execute 3: ALU result to A (ADD/SUB)

module sap1_controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       cp,
    output logic       ep,
    output logic       n_lm,
    output logic       n_ce,
    output logic       n_li,
    output logic       n_ei,
    output logic       n_la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       n_lb,
    output logic       n_lo,
    output logic       halted
);

    // The ring is held encoded and decoded to one-hot, so t_state can never
    // be all-zero or multi-hot whatever happens to the state register.
    typedef enum logic [2:0] {
        S_T1 = 3'd0,
        S_T2 = 3'd1,
        S_T3 = 3'd2,
        S_T4 = 3'd3,
        S_T5 = 3'd4,
        S_T6 = 3'd5
    } ring_t;

    ring_t ring;
    logic  halted_q;

    // Ring advance on the falling edge; HLT freezes the ring in T4.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            ring     <= S_T1;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            case (ring)
                S_T1: ring <= S_T2;
                S_T2: ring <= S_T3;
                S_T3: ring <= S_T4;
                S_T4: begin
                    if (opcode == OP_HLT) begin
                        halted_q <= 1'b1;
                    end else begin
                        ring <= S_T5;
                    end
                end
                S_T5: ring <= S_T6;
                S_T6: ring <= S_T1;
                default: ring <= S_T1;
            endcase
        end
    end

    // One-hot view of the ring; bit0 = T1.
    always_comb begin
        t_state = 6'b000001;
        case (ring)
            S_T1: t_state = 6'b000001;
            S_T2: t_state = 6'b000010;
            S_T3: t_state = 6'b000100;
            S_T4: t_state = 6'b001000;
            S_T5: t_state = 6'b010000;
            S_T6: t_state = 6'b100000;
            default: t_state = 6'b000001;
        endcase
    end

    // Microcode decode: start from the NOP word and pull only the lines each
    // state needs. Opcode is only consulted in T4..T6, after the IR has loaded.
    always_comb begin
        cp   = 1'b0;
        ep   = 1'b0;
        n_lm = 1'b1;
        n_ce = 1'b1;
        n_li = 1'b1;
        n_ei = 1'b1;
        n_la = 1'b1;
        ea   = 1'b0;
        su   = 1'b0;
        eu   = 1'b0;
        n_lb = 1'b1;
        n_lo = 1'b1;
        if (!halted_q) begin
            case (ring)
                S_T1: begin
                    ep   = 1'b1;
                    n_lm = 1'b0;
                end
                S_T2: begin
                    cp = 1'b1;
                end
                S_T3: begin
                    n_ce = 1'b0;
                    n_li = 1'b0;
                end
                S_T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            n_lm = 1'b0;
                            n_ei = 1'b0;
                            su   = (opcode == OP_SUB);
                        end
                        OP_OUT: begin
                            ea   = 1'b1;
                            n_lo = 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_T5: begin
                    case (opcode)
                        OP_LDA: begin
                            n_ce = 1'b0;
                            n_la = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            n_ce = 1'b0;
                            n_lb = 1'b0;
                            su   = (opcode == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                S_T6: begin
                    case (opcode)
                        OP_ADD, OP_SUB: begin
                            n_la = 1'b0;
                            eu   = 1'b1;
                            su   = (opcode == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign halted = halted_q;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Directed bench for the SAP-1 controller-sequencer.
module tb_sap1_controller_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo, halted;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    // word = {cp,ep,n_lm,n_ce,n_li,n_ei,n_la,ea,su,eu,n_lb,n_lo}
    localparam logic [11:0] NOP   = 12'b0011_1110_0011;
    localparam logic [11:0] M_CP  = 12'b1000_0000_0000;
    localparam logic [11:0] M_EP  = 12'b0100_0000_0000;
    localparam logic [11:0] M_NLM = 12'b0010_0000_0000;
    localparam logic [11:0] M_NCE = 12'b0001_0000_0000;
    localparam logic [11:0] M_NLI = 12'b0000_1000_0000;
    localparam logic [11:0] M_NEI = 12'b0000_0100_0000;
    localparam logic [11:0] M_NLA = 12'b0000_0010_0000;
    localparam logic [11:0] M_EA  = 12'b0000_0001_0000;
    localparam logic [11:0] M_SU  = 12'b0000_0000_1000;
    localparam logic [11:0] M_EU  = 12'b0000_0000_0100;
    localparam logic [11:0] M_NLB = 12'b0000_0000_0010;
    localparam logic [11:0] M_NLO = 12'b0000_0000_0001;

    localparam logic [11:0] W_T1      = NOP ^ M_EP ^ M_NLM;
    localparam logic [11:0] W_T2      = NOP ^ M_CP;
    localparam logic [11:0] W_T3      = NOP ^ M_NCE ^ M_NLI;
    localparam logic [11:0] W_LDA_T4  = NOP ^ M_NLM ^ M_NEI;
    localparam logic [11:0] W_LDA_T5  = NOP ^ M_NCE ^ M_NLA;
    localparam logic [11:0] W_ADD_T4  = NOP ^ M_NLM ^ M_NEI;
    localparam logic [11:0] W_ADD_T5  = NOP ^ M_NCE ^ M_NLB;
    localparam logic [11:0] W_ADD_T6  = NOP ^ M_NLA ^ M_EU;
    localparam logic [11:0] W_SUB_T4  = W_ADD_T4 ^ M_SU;
    localparam logic [11:0] W_SUB_T5  = W_ADD_T5 ^ M_SU;
    localparam logic [11:0] W_SUB_T6  = W_ADD_T6 ^ M_SU;
    localparam logic [11:0] W_OUT_T4  = NOP ^ M_EA ^ M_NLO;

    logic [11:0] word;
    assign word = {cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo};

    sap1_controller_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .t_state (t_state),
        .cp      (cp),
        .ep      (ep),
        .n_lm    (n_lm),
        .n_ce    (n_ce),
        .n_li    (n_li),
        .n_ei    (n_ei),
        .n_la    (n_la),
        .ea      (ea),
        .su      (su),
        .eu      (eu),
        .n_lb    (n_lb),
        .n_lo    (n_lo),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] t_exp,
                       input logic [11:0] w_exp, input logic h_exp);
        checks++;
        assert (t_state === t_exp) else begin
            errors++;
            $display("FAIL %s t_state got=%b exp=%b", tag, t_state, t_exp);
            $error("check %s t_state", tag);
        end
        checks++;
        assert (word === w_exp) else begin
            errors++;
            $display("FAIL %s word got=%b exp=%b", tag, word, w_exp);
            $error("check %s word", tag);
        end
        checks++;
        assert (halted === h_exp) else begin
            errors++;
            $display("FAIL %s halted got=%b exp=%b", tag, halted, h_exp);
            $error("check %s halted", tag);
        end
    endtask

    // Invariants sampled at each rising edge, where the datapath acts.
    always @(posedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            assert ($onehot(t_state)) else begin
                errors++;
                $display("FAIL inv_onehot t_state got=%b exp=one-hot", t_state);
                $error("invariant one-hot");
            end
            checks++;
            assert ((32'(ep) + 32'(!n_ce) + 32'(!n_ei) + 32'(ea) + 32'(eu)) <= 1) else begin
                errors++;
                $display("FAIL inv_bus drivers word=%b exp=at most one", word);
                $error("invariant bus");
            end
        end
    end

    initial begin
        rst    = 1'b1;
        opcode = 4'b0000;
        #3;
        chk("reset", T1, W_T1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // LDA, with opcode noise during fetch that must not matter
        step(); chk("lda_t2", T2, W_T2, 1'b0);
        opcode = 4'b1110;
        #1; chk("lda_t2_noise", T2, W_T2, 1'b0);
        step(); chk("lda_t3", T3, W_T3, 1'b0);
        opcode = 4'b0000;
        step(); chk("lda_t4", T4, W_LDA_T4, 1'b0);
        step(); chk("lda_t5", T5, W_LDA_T5, 1'b0);
        step(); chk("lda_t6", T6, NOP, 1'b0);
        step(); chk("lda_wrap", T1, W_T1, 1'b0);

        // ADD, reset asserted mid-T5
        opcode = 4'b0001;
        step(); chk("add_t2", T2, W_T2, 1'b0);
        step(); chk("add_t3", T3, W_T3, 1'b0);
        step(); chk("add_t4", T4, W_ADD_T4, 1'b0);
        step(); chk("add_t5", T5, W_ADD_T5, 1'b0);
        #2;
        rst = 1'b1;
        #1; chk("rst_mid_t5", T1, W_T1, 1'b0);
        @(posedge clk); #1;
        chk("rst_held", T1, W_T1, 1'b0);
        rst = 1'b0;
        step(); chk("rst_rel_t2", T2, W_T2, 1'b0);
        step(); chk("add2_t3", T3, W_T3, 1'b0);
        step(); chk("add2_t4", T4, W_ADD_T4, 1'b0);
        step(); chk("add2_t5", T5, W_ADD_T5, 1'b0);
        step(); chk("add2_t6", T6, W_ADD_T6, 1'b0);
        step(); chk("add2_wrap", T1, W_T1, 1'b0);

        // SUB
        opcode = 4'b0010;
        step(); chk("sub_t2", T2, W_T2, 1'b0);
        step(); chk("sub_t3", T3, W_T3, 1'b0);
        step(); chk("sub_t4", T4, W_SUB_T4, 1'b0);
        step(); chk("sub_t5", T5, W_SUB_T5, 1'b0);
        step(); chk("sub_t6", T6, W_SUB_T6, 1'b0);
        step(); chk("sub_wrap", T1, W_T1, 1'b0);

        // OUT
        opcode = 4'b1110;
        step(); step(); chk("out_t3", T3, W_T3, 1'b0);
        step(); chk("out_t4", T4, W_OUT_T4, 1'b0);
        step(); chk("out_t5", T5, NOP, 1'b0);
        step(); chk("out_t6", T6, NOP, 1'b0);
        step(); chk("out_wrap", T1, W_T1, 1'b0);

        // Illegal opcode
        opcode = 4'b0111;
        step(); step();
        step(); chk("ill_t4", T4, NOP, 1'b0);
        step(); chk("ill_t5", T5, NOP, 1'b0);
        step(); chk("ill_t6", T6, NOP, 1'b0);
        step(); chk("ill_wrap", T1, W_T1, 1'b0);

        // Sweep all non-halting opcodes; invariants run in the background
        for (int op = 0; op < 15; op++) begin
            opcode = 4'(op);
            repeat (6) step();
            chk($sformatf("sweep_%0d", op), T1, W_T1, 1'b0);
        end

        // HLT
        opcode = 4'b1111;
        step(); chk("hlt_t2", T2, W_T2, 1'b0);
        step(); chk("hlt_t3", T3, W_T3, 1'b0);
        step(); chk("hlt_t4", T4, NOP, 1'b0);
        step(); chk("hlt_freeze", T4, NOP, 1'b1);
        opcode = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("hlt_hold_%0d", i), T4, NOP, 1'b1);
        end
        #2;
        rst = 1'b1;
        #1; chk("hlt_rst", T1, W_T1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(); chk("hlt_rel_t2", T2, W_T2, 1'b0);
        step(); chk("hlt_rel_t3", T3, W_T3, 1'b0);
        step(); chk("hlt_rel_t4", T4, W_ADD_T4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
